vram_arbiter: RTL
=================

Name: vram_arbiter

Overview:
- Shares the single GPU-side port of the VRAM controller between N_REQ GPU-internal requesters (e.g. rasterizer pixel writes, texture/CLUT reads, CPU-to-VRAM DMA).
- Arbitration is round-robin, with optional locked bursts for streaming requesters.
- Respects the controller's GPU_en stall, which drops while a VGA scanline fetch owns the SRAM.
- Returns registered read data tagged to the requester that issued the read.

Parameters:
- N_REQ, 3, number of requesters (2..8).
- MAX_BURST, 8, maximum consecutive beats granted to a locked requester before a forced rotation (1..255).

Ports:
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- req  in  N_REQ  per-requester access request; held until granted.
- req_we  in  N_REQ  1 = write, 0 = read; per requester.
- req_lock  in  N_REQ  requester wants to keep the port for following beats.
- req_addr  in  N_REQ*19  packed VRAM word addresses; requester i is at [19*i+18:19*i].
- req_wdata  in  N_REQ*16  packed write data.
- gnt  out  N_REQ  one-hot; the access of requester i is performed this cycle.
- rdata  out  16  registered read data.
- rvalid  out  N_REQ  one-hot; rdata belongs to requester i.
- GPU_en  in  1  from VRAM controller; 1 = port accepts an access this cycle.
- GPU_re, GPU_we  out  1  to VRAM controller.
- GPU_addr  out  19  to VRAM controller.
- GPU_data_out  out  16  write data to controller (its GPU_data_in).
- GPU_data_in  in  16  read data from controller (combinational SRAM data).

Behaviour:
- Reset (rst_n low, async):
  - gnt=0, rvalid=0, rdata=0, GPU_re=GPU_we=0, GPU_addr=0, GPU_data_out=0.
  - rr_ptr=0, state=ARB, burst_cnt=0, owner=0.
- Selection in state ARB (combinational):
  - Candidate = first i with req[i]=1, scanning rr_ptr, rr_ptr+1, ... mod N_REQ.
  - No req → GPU_re=GPU_we=0 and all outputs idle.
- Selection in state BURST: candidate = owner only, and only if req[owner]=1.
- Drive: for the candidate, GPU_re=~req_we[c], GPU_we=req_we[c], GPU_addr=req_addr[c], GPU_data_out=req_wdata[c], asserted regardless of GPU_en.
- Grant: gnt[c]=req[c]&GPU_en, combinational, same cycle as the access. With GPU_en=0 nothing is granted and no state changes. The requester keeps request, address and data stable until gnt.
- Read return: a granted read latches GPU_data_in into rdata at the clock edge. rvalid[c]=1 for exactly the next cycle. Read latency is 1 cycle after gnt. Back-to-back reads give one rvalid per cycle.
- Writes produce no rvalid.
- Grant in ARB:
  - If req_lock[c]=1 and MAX_BURST>1: owner<=c, burst_cnt<=1, state<=BURST.
  - Else rr_ptr<=c+1 mod N_REQ.
- Grant in BURST: burst_cnt increments.
- Exit BURST to ARB, with rr_ptr<=owner+1, when any of:
  - req_lock[owner] is sampled low on a granted beat;
  - burst_cnt reaches MAX_BURST on a granted beat;
  - req[owner]=0 in any cycle (burst abandoned, port released immediately).
- GPU_en low during BURST: burst_cnt and state hold; the burst resumes when GPU_en returns.
- Fairness: with all requesters continuously requesting unlocked, each is granted once every N_REQ granted cycles.
- Reset mid-burst or mid-read: the pending rvalid is dropped and the arbiter restarts in ARB with rr_ptr=0.
- No combinational path from GPU_en to GPU_re/GPU_we/GPU_addr. The only GPU_en-dependent output is gnt.

Test Plan:
- Reset, then req=3'b001 read at addr 0x00123 with GPU_data_in=0xABCD, GPU_en=1 → gnt=001 in cycle 0, GPU_re=1, GPU_addr=0x00123; cycle 1 rdata=0xABCD, rvalid=001.
- All three requesters write continuously, unlocked, GPU_en=1 → grant order 001,010,100,001,... (one per cycle, 6 grants covers two rotations).
- Requester 1 holds req and lock with MAX_BURST=8, others requesting → exactly 8 consecutive gnt=010, then gnt=100, then 001.
- Burst owner drops lock after beat 3 → beat 3 granted, next grant goes to requester 2.
- GPU_en held low for 5 cycles mid-stream (VGA fetch) → gnt=0 throughout, GPU_addr stable, burst_cnt frozen; resumes on the same requester when GPU_en=1.
- rst_n low during a burst, in the cycle after a read grant → rvalid=0 immediately; after release, req=100 only → gnt=100 on first cycle.

Source files
------------

// File: rtl/vram_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : vram_arbiter
//  Purpose  : Shares the GPU-side port of the VRAM controller between N_REQ
//             internal requesters. Round-robin arbitration with optional
//             locked bursts (bounded by MAX_BURST), honouring the
//             controller's GPU_en stall. Read data is registered and tagged
//             to the requester that issued the read.
//  Revision : 1.0  initial release
// ----------------------------------------------------------------------------
//  Ports
//    clk, rst_n        clock, asynchronous active-low reset
//    req/req_we/req_lock  per-requester request, write flag, burst lock
//    req_addr          packed 19-bit word addresses (requester i at [19i+:19])
//    req_wdata         packed 16-bit write data    (requester i at [16i+:16])
//    gnt               one-hot, access of requester i performed this cycle
//    rdata, rvalid     registered read data and its one-hot owner tag
//    GPU_en            controller accepts an access this cycle
//    GPU_re/GPU_we/GPU_addr/GPU_data_out  access to the controller
//    GPU_data_in       read data from the controller
// ============================================================================
module vram_arbiter #(
  parameter int N_REQ     = 3,
  parameter int MAX_BURST = 8
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic [N_REQ-1:0]      req,
  input  logic [N_REQ-1:0]      req_we,
  input  logic [N_REQ-1:0]      req_lock,
  input  logic [N_REQ*19-1:0]   req_addr,
  input  logic [N_REQ*16-1:0]   req_wdata,
  output logic [N_REQ-1:0]      gnt,
  output logic [15:0]           rdata,
  output logic [N_REQ-1:0]      rvalid,
  input  logic                  GPU_en,
  output logic                  GPU_re,
  output logic                  GPU_we,
  output logic [18:0]           GPU_addr,
  output logic [15:0]           GPU_data_out,
  input  logic [15:0]           GPU_data_in
);

  localparam int IDX_W = (N_REQ > 1) ? $clog2(N_REQ) : 1;

  typedef enum logic [0:0] {
    ARB   = 1'b0,
    BURST = 1'b1
  } state_t;

  state_t           state;
  logic [IDX_W-1:0] rr_ptr;
  logic [IDX_W-1:0] owner;
  logic [7:0]       burst_cnt;

  logic [IDX_W-1:0] cand;
  logic             found;
  logic [IDX_W-1:0] scan;
  logic             burst_done;

  // Modulo-N_REQ increment of a requester index.
  function automatic logic [IDX_W-1:0] next_idx(input logic [IDX_W-1:0] i);
    if (i == IDX_W'(N_REQ - 1))
      next_idx = '0;
    else
      next_idx = i + IDX_W'(1);
  endfunction

  // Candidate selection: in BURST only the owner may use the port; in ARB
  // scan from rr_ptr upwards (wrapping) and take the first active request.
  always_comb begin
    found = 1'b0;
    cand  = '0;
    scan  = rr_ptr;
    if (state == BURST) begin
      found = req[owner];
      cand  = owner;
    end else begin
      for (int k = 0; k < N_REQ; k++) begin
        if (!found && req[scan]) begin
          found = 1'b1;
          cand  = scan;
        end
        scan = next_idx(scan);
      end
    end
  end

  // Port drive depends only on requests and arbiter state, never on GPU_en,
  // so the controller sees a stable access while it stalls us.
  always_comb begin
    GPU_re       = 1'b0;
    GPU_we       = 1'b0;
    GPU_addr     = '0;
    GPU_data_out = '0;
    gnt          = '0;
    if (rst_n && found) begin
      GPU_re       = ~req_we[cand];
      GPU_we       = req_we[cand];
      GPU_addr     = req_addr[int'(cand)*19 +: 19];
      GPU_data_out = req_wdata[int'(cand)*16 +: 16];
      if (GPU_en)
        gnt[cand] = 1'b1;
    end
  end

  // A granted burst beat ends the burst when the owner releases its lock or
  // the beat count (including this beat) reaches MAX_BURST.
  assign burst_done = !req_lock[owner] ||
                      (({1'b0, burst_cnt} + 9'd1) >= 9'(MAX_BURST));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ARB;
      rr_ptr    <= '0;
      owner     <= '0;
      burst_cnt <= '0;
      rdata     <= '0;
      rvalid    <= '0;
    end else begin
      rvalid <= gnt & ~req_we;
      if (|(gnt & ~req_we))
        rdata <= GPU_data_in;

      if (found && GPU_en) begin
        if (state == ARB) begin
          if (req_lock[cand] && (MAX_BURST > 1)) begin
            owner     <= cand;
            burst_cnt <= 8'd1;
            state     <= BURST;
          end else begin
            rr_ptr <= next_idx(cand);
          end
        end else if (burst_done) begin
          state     <= ARB;
          burst_cnt <= '0;
          rr_ptr    <= next_idx(owner);
        end else begin
          burst_cnt <= burst_cnt + 8'd1;
        end
      end else if (state == BURST && !req[owner]) begin
        // Owner abandoned the burst: release the port right away.
        state     <= ARB;
        burst_cnt <= '0;
        rr_ptr    <= next_idx(owner);
      end
    end
  end

endmodule
`default_nettype wire
